dmux_16_stream: RTL

- Registered 16-bit stream demultiplexer: the distribution-side counterpart of the 16-bit two-input mux.
- Routes each accepted input beat to output port a (sel=0) or port b (sel=1).
- Each output port has a one-entry holding register with a valid/ready handshake.
- Each port keeps a wrap-around count of completed output beats, for use on datapaths feeding two independent consumers.

---
 rtl/dmux_pkg.sv | 10 +
 rtl/dmux_slot.sv | 53 +++++
 rtl/dmux_16_stream.sv | 66 ++++++
 3 files changed

// File: rtl/dmux_pkg.sv
// Shared defaults and port indices for the 16-bit stream demultiplexer.
package dmux_pkg;

    localparam int unsigned DMUX_WIDTH = 16;
    localparam int unsigned DMUX_CNT_W = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dmux_slot.sv
// One output port: holding register, full flag and completed-beat counter.
module dmux_slot
    import dmux_pkg::*;
#(
    parameter int unsigned WIDTH = DMUX_WIDTH,
    parameter int unsigned CNT_W = DMUX_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    logic             full_q,  full_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] count_q, count_d;

    // A load in the same cycle as a drain wins, keeping the slot full.
    always_comb begin
        full_d  = full_q;
        data_d  = data_q;
        count_d = count_q;
        if (full_q && ready) begin
            full_d  = 1'b0;
            count_d = count_q + 1'b1;
        end
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid = full_q;
    assign data  = data_q;
    assign count = count_q;

endmodule

// File: rtl/dmux_16_stream.sv
// Registered stream demultiplexer: routes each accepted beat to port a or b.
module dmux_16_stream
    import dmux_pkg::*;
#(
    parameter int unsigned WIDTH = DMUX_WIDTH,
    parameter int unsigned CNT_W = DMUX_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic load_a;
    logic load_b;

    // Only the selected port can stall the input.
    always_comb begin
        if (in_sel == PORT_B) begin
            in_ready = !b_valid || b_ready;
        end else begin
            in_ready = !a_valid || a_ready;
        end
        load_a = in_valid && in_ready && (in_sel == PORT_A);
        load_b = in_valid && in_ready && (in_sel == PORT_B);
    end

    dmux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk       (clk),
        .reset     (reset),
        .load      (load_a),
        .load_data (in_data),
        .ready     (a_ready),
        .valid     (a_valid),
        .data      (a_data),
        .count     (a_count)
    );

    dmux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk       (clk),
        .reset     (reset),
        .load      (load_b),
        .load_data (in_data),
        .ready     (b_ready),
        .valid     (b_valid),
        .data      (b_data),
        .count     (b_count)
    );

endmodule
